// File: rtl/cpu_run_ctrl_if.sv
// Host/debug access port into the shared data memory.
// The host drives the request side; cpu_run_ctrl answers with ack and read data.
interface cpu_run_ctrl_if #(
  parameter int W = 16
);
  logic         req;
  logic         we;
  logic [W-1:0] addr;
  logic [W-1:0] wdata;
  logic         ack;
  logic [W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for cpu_core plus data-memory arbiter between the
// core and the host port. The host steals single cycles while the CPU runs;
// during a steal the core is stalled by dropping cpu_run_en.
//
// state | meaning
// RESET | cpu_rst held for RST_CYCLES cycles, commands ignored, no host grant
// IDLE  | core paused, waiting for run/step
// RUN   | core free-running, watchdog counting
// STEP  | exactly one instruction executed, then IDLE (or HALT)
// HALT  | HALT opcode or watchdog expiry; only cmd_cpu_reset leaves
module cpu_run_ctrl #(
  parameter int         IA_W       = 12,
  parameter int         W          = 16,
  parameter int         CW         = 32,
  parameter int         RST_CYCLES = 2,
  parameter int         MAX_RUN    = 0,
  parameter logic [3:0] HALT_OP    = 4'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_run,
  input  logic          cmd_step,
  input  logic          cmd_stop,
  input  logic          cmd_cpu_reset,
  input  logic [W-1:0]  cpu_instr,
  output logic          cpu_rst,
  output logic          cpu_run_en,
  input  logic [W-1:0]  cpu_mem_addr,
  input  logic [W-1:0]  cpu_mem_wdata,
  input  logic          cpu_mem_we,
  input  logic          cpu_mem_re,
  output logic [W-1:0]  cpu_mem_rdata,
  cpu_run_ctrl_if.slave host,
  output logic [W-1:0]  dmem_addr,
  output logic [W-1:0]  dmem_wdata,
  output logic          dmem_we,
  output logic          dmem_re,
  input  logic [W-1:0]  dmem_rdata,
  output logic [2:0]    state,
  output logic          timeout,
  output logic [CW-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam int WDW = (MAX_RUN > 0) ? $clog2(MAX_RUN + 1) : 1;
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(MAX_RUN);

  state_t         st;
  logic [RCW-1:0] rst_cnt;
  logic [WDW-1:0] wd;
  logic [WDW-1:0] wd_inc;
  logic           wd_hit;
  logic           grant;
  logic           is_halt_op;
  logic           retire;
  logic [CW-1:0]  cnt_inc;

  // Address/immediate field of the instruction is the core's business, not ours.
  wire unused_instr_bits = ^cpu_instr[IA_W-1:0];

  assign state         = st;
  assign cpu_mem_rdata = dmem_rdata;

  // Arbitration, stall and retire decode; a host grant is refused in the
  // cycle right after an ack so a held request gets every 2nd cycle at most.
  always_comb begin
    is_halt_op = (cpu_instr[15:12] == HALT_OP);
    grant      = host.req & ~host.ack &
                 ((st == S_IDLE) | (st == S_RUN) | (st == S_HALT));
    cpu_run_en = ((st == S_RUN) & ~grant) | (st == S_STEP);
    retire     = cpu_run_en & ~is_halt_op;
    cnt_inc    = (instr_count == '1) ? instr_count : instr_count + 1'b1;
    wd_inc     = wd + 1'b1;
    wd_hit     = (MAX_RUN != 0) && (wd_inc == WD_LIMIT);
  end

  // Data-memory mux: host wins the port in a grant cycle, otherwise the core
  // owns it but its strobes only count while it is actually executing.
  always_comb begin
    if (grant) begin
      dmem_addr  = host.addr;
      dmem_wdata = host.wdata;
      dmem_we    = host.we;
      dmem_re    = ~host.we;
    end else begin
      dmem_addr  = cpu_mem_addr;
      dmem_wdata = cpu_mem_wdata;
      dmem_we    = cpu_mem_we & cpu_run_en;
      dmem_re    = cpu_mem_re & cpu_run_en;
    end
  end

  // Sequencer FSM with registered cpu_rst, watchdog, timeout flag and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= S_RESET;
      rst_cnt     <= '0;
      cpu_rst     <= 1'b1;
      wd          <= '0;
      timeout     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (retire) instr_count <= cnt_inc;
      case (st)
        S_RESET: begin
          if (rst_cnt == RST_LAST) begin
            st      <= S_IDLE;
            cpu_rst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_IDLE, S_RUN, S_HALT: begin
          if (cmd_cpu_reset) begin
            st          <= S_RESET;
            cpu_rst     <= 1'b1;
            rst_cnt     <= '0;
            wd          <= '0;
            timeout     <= 1'b0;
            instr_count <= '0;
          end else if (st == S_IDLE) begin
            if (cmd_stop) begin
              st <= S_IDLE;
            end else if (cmd_step) begin
              st <= S_STEP;
            end else if (cmd_run) begin
              st <= S_RUN;
              wd <= '0;
            end
          end else if (st == S_RUN) begin
            if (cmd_stop) begin
              st <= S_IDLE;
            end else if (cpu_run_en && is_halt_op) begin
              st <= S_HALT;
            end else begin
              wd <= wd_inc;
              if (wd_hit) begin
                st      <= S_HALT;
                timeout <= 1'b1;
              end
            end
          end
        end
        S_STEP: st <= is_halt_op ? S_HALT : S_IDLE;
        default: begin
          st      <= S_RESET;
          cpu_rst <= 1'b1;
          rst_cnt <= '0;
        end
      endcase
    end
  end

  // Host completion: ack and captured read data one cycle after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host.ack   <= 1'b0;
      host.rdata <= '0;
    end else begin
      host.ack <= grant;
      if (grant) host.rdata <= dmem_rdata;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a tiny behavioural core (ADDI/JMP/ST/HALT) and data
// memory around the controller; host accesses go through a scoreboard queue.
module tb_cpu_run_ctrl;
  localparam int W  = 16;
  localparam int CW = 3;
  localparam logic [2:0] S_RESET = 3'd0, S_IDLE = 3'd1, S_RUN = 3'd2,
                         S_STEP = 3'd3, S_HALT = 3'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_run, cmd_step, cmd_stop, cmd_cpu_reset;
  logic [W-1:0]  cpu_instr;
  logic          cpu_rst, cpu_run_en;
  logic [W-1:0]  cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
  logic          cpu_mem_we, cpu_mem_re;
  logic [W-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic          dmem_we, dmem_re;
  logic [2:0]    state;
  logic          timeout;
  logic [CW-1:0] instr_count;

  cpu_run_ctrl_if #(.W(W)) hbus ();

  cpu_run_ctrl #(
    .IA_W(12), .W(W), .CW(CW), .RST_CYCLES(2), .MAX_RUN(8), .HALT_OP(4'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop),
    .cmd_cpu_reset(cmd_cpu_reset),
    .cpu_instr(cpu_instr), .cpu_rst(cpu_rst), .cpu_run_en(cpu_run_en),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_we(cpu_mem_we), .cpu_mem_re(cpu_mem_re), .cpu_mem_rdata(cpu_mem_rdata),
    .host(hbus.slave),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
    .state(state), .timeout(timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Behavioural core: opcode 1 ADDI, 2 JMP, 3 ST imm[11:8] -> addr[7:0], 0 HALT.
  logic [15:0] rom [0:15];
  logic [15:0] mem [0:255];
  logic [11:0] pc;
  logic [15:0] acc;

  assign cpu_instr     = rom[pc[3:0]];
  assign cpu_mem_we    = (cpu_instr[15:12] == 4'h3);
  assign cpu_mem_re    = 1'b0;
  assign cpu_mem_addr  = {8'h00, cpu_instr[7:0]};
  assign cpu_mem_wdata = {12'h000, cpu_instr[11:8]};
  assign dmem_rdata    = mem[dmem_addr[7:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 5) ? 16'h1234 : 16'h0000;
    end else if (dmem_we) begin
      mem[dmem_addr[7:0]] <= dmem_wdata;
    end
    if (cpu_rst) begin
      pc  <= '0;
      acc <= '0;
    end else if (cpu_run_en) begin
      case (cpu_instr[15:12])
        4'h0: pc <= pc;
        4'h1: begin pc <= pc + 1'b1; acc <= acc + {8'h00, cpu_instr[7:0]}; end
        4'h2: pc <= cpu_instr[11:0];
        default: pc <= pc + 1'b1;
      endcase
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one cycle; any host ack seen is matched against the scoreboard.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    if (hbus.ack) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("host_rdata", 32'(hbus.rdata), 32'(e));
      end
    end
  endtask

  task automatic run_cycles_in(input logic [2:0] s, output int n);
    n = 0;
    while (state == s && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic cpu_reset_cmd();
    cmd_cpu_reset = 1'b1;
    tick();
    cmd_cpu_reset = 1'b0;
    check("rstcmd_state", 32'(state), 32'(S_RESET));
    check("rstcmd_timeout", 32'(timeout), 0);
    check("rstcmd_count", 32'(instr_count), 0);
    tick();
    tick();
    check("rstcmd_idle", 32'(state), 32'(S_IDLE));
  endtask

  task automatic pulse_run();
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
  endtask

  task automatic host_xfer(input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp);
    if (hbus.ack) tick();
    hbus.req = 1'b1; hbus.we = we; hbus.addr = addr; hbus.wdata = wdata;
    exp_q.push_back(exp);
    tick();
    hbus.req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int n_ack;
    logic pred_ack, g;
    rst = 1'b1;
    cmd_run = 0; cmd_step = 0; cmd_stop = 0; cmd_cpu_reset = 0;
    hbus.req = 0; hbus.we = 0; hbus.addr = '0; hbus.wdata = '0;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1001; rom[1] = 16'h1002; rom[2] = 16'h1003; rom[3] = 16'h0000;
    repeat (3) tick();
    check("rst_state", 32'(state), 32'(S_RESET));
    check("rst_cpu_rst", 32'(cpu_rst), 1);
    check("rst_ack", 32'(hbus.ack), 0);
    check("rst_run_en", 32'(cpu_run_en), 0);

    // T1: cpu_rst held exactly two cycles after rst release
    rst = 1'b0;
    n = 0;
    while (cpu_rst && n < 10) begin n++; tick(); end
    check("t1_rst_cycles", 32'(n), 2);
    check("t1_state", 32'(state), 32'(S_IDLE));
    check("t1_run_en", 32'(cpu_run_en), 0);
    check("t1_count", 32'(instr_count), 0);

    // T2: 3 ADDI then HALT
    pulse_run();
    run_cycles_in(S_RUN, n);
    check("t2_run_cycles", 32'(n), 4);
    check("t2_state", 32'(state), 32'(S_HALT));
    check("t2_count", 32'(instr_count), 3);
    check("t2_run_en", 32'(cpu_run_en), 0);
    check("t2_acc", 32'(acc), 6);
    pulse_run();
    cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    check("t2_halt_sticky", 32'(state), 32'(S_HALT));
    check("t2_count_hold", 32'(instr_count), 3);
    cpu_reset_cmd();

    // T3: two single steps
    for (int k = 0; k < 2; k++) begin
      cmd_step = 1'b1; tick(); cmd_step = 1'b0;
      check("t3_step_state", 32'(state), 32'(S_STEP));
      check("t3_step_en", 32'(cpu_run_en), 1);
      tick();
      check("t3_back_idle", 32'(state), 32'(S_IDLE));
      check("t3_en_low", 32'(cpu_run_en), 0);
    end
    check("t3_count", 32'(instr_count), 2);
    check("t3_pc", 32'(pc), 2);

    // Host: held read request granted every 2nd cycle; then write/read-back
    hbus.req = 1'b1; hbus.we = 1'b0; hbus.addr = 16'd5;
    pred_ack = 1'b0; n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      g = ~pred_ack;
      if (g) exp_q.push_back(16'h1234);
      tick();
      n_ack += int'(hbus.ack);
      pred_ack = g;
    end
    hbus.req = 1'b0;
    check("held_req_acks", 32'(n_ack), 3);
    tick();
    host_xfer(1'b1, 16'd7, 16'hBEEF, 16'h0000);
    host_xfer(1'b0, 16'd7, 16'h0000, 16'hBEEF);

    // T4: host steal during RUN stalls the core for one cycle
    rom[0] = 16'h1001; rom[1] = 16'h3A09; rom[2] = 16'h1001;
    rom[3] = 16'h1001; rom[4] = 16'h0000;
    cpu_reset_cmd();
    pulse_run();
    tick();
    hbus.req = 1'b1; hbus.we = 1'b0; hbus.addr = 16'd5;
    exp_q.push_back(16'h1234);
    #1;
    check("t4_steal_en", 32'(cpu_run_en), 0);
    check("t4_steal_addr", 32'(dmem_addr), 5);
    check("t4_steal_re", 32'(dmem_re), 1);
    check("t4_steal_we", 32'(dmem_we), 0);
    tick();
    hbus.req = 1'b0;
    #1;
    check("t4_pc_held", 32'(pc), 1);
    check("t4_en_back", 32'(cpu_run_en), 1);
    check("t4_st_we", 32'(dmem_we), 1);
    check("t4_st_addr", 32'(dmem_addr), 9);
    run_cycles_in(S_RUN, n);
    check("t4_run_rest", 32'(n), 4);
    check("t4_state", 32'(state), 32'(S_HALT));
    check("t4_count", 32'(instr_count), 4);
    check("t4_acc", 32'(acc), 3);
    host_xfer(1'b0, 16'd9, 16'h0000, 16'h000A);

    // T5: infinite loop trips the 8-cycle watchdog; count saturates at 7
    rom[0] = 16'h1001; rom[1] = 16'h2000;
    cpu_reset_cmd();
    pulse_run();
    run_cycles_in(S_RUN, n);
    check("t5_run_cycles", 32'(n), 8);
    check("t5_state", 32'(state), 32'(S_HALT));
    check("t5_timeout", 32'(timeout), 1);
    check("t5_count_sat", 32'(instr_count), 7);
    cpu_reset_cmd();
    check("t5_timeout_clr", 32'(timeout), 0);

    // T6: stop and step together in RUN -> stop wins; watchdog restarts on rerun
    pulse_run();
    tick();
    tick();
    cmd_stop = 1'b1; cmd_step = 1'b1;
    tick();
    cmd_stop = 1'b0; cmd_step = 1'b0;
    check("t6_state", 32'(state), 32'(S_IDLE));
    check("t6_count", 32'(instr_count), 3);
    tick();
    check("t6_no_step", 32'(state), 32'(S_IDLE));
    check("t6_count_hold", 32'(instr_count), 3);
    pulse_run();
    run_cycles_in(S_RUN, n);
    check("t6_wd_restart", 32'(n), 8);
    check("t6_timeout", 32'(timeout), 1);
    check("t6_count_sat", 32'(instr_count), 7);

    tick();
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
